// File: rtl/cc_serializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cc_serializer: 512-bit cache line to 8 x 64-bit AXI R beats,     |
// | critical word first with wrapping order.          Revision: 1.0  |
// +------------------------------------------------------------------+
module cc_serializer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         line_valid_i,
   input  logic [511:0] line_data_i,
   input  logic [2:0]   line_offset_i,
   output logic         line_ready_o,
   output logic [63:0]  inct_rdata_o,
   output logic         inct_rvalid_o,
   output logic         inct_rlast_o,
   input  logic         inct_rready_i
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [511:0]   line_q;
   logic [2:0]     offset_q;
   logic [2:0]     beat_q;
   logic [2:0]     word_idx;
   logic           beat_hs;
   logic           accept;

   // 3-bit add wraps 7->0, giving the critical-word-first order for free.
   assign word_idx = offset_q + beat_q;

   always_comb begin
      state_d       = state_q;
      inct_rvalid_o = 1'b0;
      inct_rlast_o  = 1'b0;
      inct_rdata_o  = 64'd0;
      line_ready_o  = 1'b0;
      beat_hs       = 1'b0;
      accept        = 1'b0;
      case (state_q)
         IDLE: begin
            line_ready_o = 1'b1;
            accept       = line_valid_i;
            if (accept) begin
               state_d = SEND;
            end
         end
         SEND: begin
            inct_rvalid_o = 1'b1;
            inct_rlast_o  = (beat_q == 3'd7);
            inct_rdata_o  = line_q[{word_idx, 6'd0} +: 64];
            beat_hs       = inct_rready_i;
            // A new line may only slip in on the final beat handshake.
            line_ready_o  = beat_hs && inct_rlast_o;
            accept        = line_valid_i && line_ready_o;
            if (beat_hs && inct_rlast_o && !accept) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         line_q   <= 512'd0;
         offset_q <= 3'd0;
         beat_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            line_q   <= line_data_i;
            offset_q <= line_offset_i;
            beat_q   <= 3'd0;
         end else if (beat_hs) begin
            beat_q <= beat_q + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/cc_serializer.md
CC_SERIALIZER -- requirements
Module: cc_serializer

Interface
REQ-001 Parameters: none; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 line_valid_i  in  1  a 512-bit cache line is offered for transmission.
REQ-005 line_data_i  in  512  line payload; word w occupies bits [64*w+63 : 64*w], w = 0..7.
REQ-006 line_offset_i  in  3  critical-word index (address bits [5:3] of the request).
REQ-007 line_ready_o  out  1  serializer accepts the offered line this cycle.
REQ-008 inct_rdata_o  out  64  AXI R-channel data beat toward the requester.
REQ-009 inct_rvalid_o  out  1  AXI R-channel valid.
REQ-010 inct_rlast_o  out  1  AXI R-channel last; marks the 8th beat.
REQ-011 inct_rready_i  in  1  AXI R-channel ready from the requester.

Function
REQ-012 A line transfer is accepted on a rising edge where line_valid_i = 1 and line_ready_o = 1; line_data_i and line_offset_i are captured into internal registers on that edge.
REQ-013 The FSM has two states: IDLE (no line held) and SEND (line held, beats outstanding).
REQ-014 Transitions: IDLE->SEND on accept; SEND->IDLE on the 8th beat handshake without a same-cycle accept; SEND->SEND on the 8th beat handshake with a same-cycle accept.
REQ-015 line_ready_o is combinational: 1 in IDLE; 1 in SEND only when inct_rvalid_o = 1, inct_rready_i = 1 and inct_rlast_o = 1; otherwise 0.
REQ-016 A beat handshake occurs on an edge where inct_rvalid_o = 1 and inct_rready_i = 1.
REQ-017 inct_rvalid_o = 1 exactly while in SEND; first beat is presented the cycle after accept (1-cycle latency).
REQ-018 A 3-bit beat counter k resets to 0 on accept and increments by 1 on each beat handshake.
REQ-019 inct_rdata_o in beat k = captured word[(offset + k) mod 8]; index arithmetic is 3-bit and wraps 7->0 (critical-word-first, wrapping order).
REQ-020 inct_rlast_o = 1 exactly when in SEND and k = 7.
REQ-021 While inct_rvalid_o = 1 and inct_rready_i = 0, inct_rdata_o, inct_rlast_o and inct_rvalid_o are held stable; k does not advance.
REQ-022 Back-to-back lines: a line accepted on the 8th beat handshake edge presents its beat 0 on the next cycle with no idle cycle between lines.
REQ-023 line_valid_i while in SEND (other than the 8th beat handshake) is not accepted; line_data_i changes then have no effect on the line in flight.
REQ-024 inct_rvalid_o does not depend combinationally on inct_rready_i.
REQ-025 inct_rdata_o is 0 whenever inct_rvalid_o = 0.
REQ-026 Each accepted line produces exactly 8 handshakes; no beat is dropped or duplicated.

Reset
REQ-027 Reset is applied when rst_n = 0 at a rising edge; it overrides any handshake on that edge.
REQ-028 After reset: state IDLE, k = 0, inct_rvalid_o = 0, inct_rlast_o = 0, inct_rdata_o = 0, line_ready_o = 1, captured line and offset = 0.
REQ-029 Reset mid-transfer discards the held line and remaining beats; the requester sees no further beats of that line.

Verification
REQ-030 Offset 0, rready held 1: line words 0x0..0x7 -> beats 0,1,...,7 on 8 consecutive cycles starting 1 cycle after accept; rlast on beat 7 only.
REQ-031 Offset 5, rready held 1 -> beat order words 5,6,7,0,1,2,3,4; rlast with word 4.
REQ-032 Offset 2, rready toggled 1,0,0,1,... -> data/rlast stable during stalls; order 2..7,0,1 preserved; exactly 8 handshakes.
REQ-033 Two lines offered back-to-back (offsets 3 then 6), rready held 1 -> 16 consecutive valid beats, no bubble; line_ready_o = 1 on the first line's rlast cycle.
REQ-034 rst_n = 0 during beat 4 of a line -> next cycle rvalid = 0, rlast = 0, rdata = 0, line_ready_o = 1; a new line afterwards starts at its own offset word.
REQ-035 line_valid_i asserted with new data during SEND stall -> line_ready_o = 0, in-flight beats unchanged, new line accepted only on the rlast handshake edge.
